// File: rtl/reprog_dump_tx.sv
// Streams a range of bootloader-RAM words out as 8N1 UART bytes, little-endian,
// driving the RAM's second read port while a dump is in progress.
module reprog_dump_tx #(
  parameter int ADDR_WIDTH  = 12,
  parameter int COUNTER_MSB = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] startAddr_i,
  input  logic [ADDR_WIDTH:0]   wordCount_i,
  input  logic [COUNTER_MSB:0]  halfPeriod_i,
  output logic [ADDR_WIDTH-1:0] memAddr_o,
  output logic                  memEn_o,
  input  logic [31:0]           memData_i,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [2:0] {
    IDLE, EMPTY, READ, LATCH, START, DATA, STOP, DONE
  } state_t;

  localparam logic [COUNTER_MSB:0]  CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = 1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     rem_q, rem_d;
  logic [COUNTER_MSB:0]    hp_q, hp_d;
  logic [COUNTER_MSB:0]    cnt_q, cnt_d;
  logic                    half_q, half_d;
  logic [2:0]              bitIdx_q, bitIdx_d;
  logic [1:0]              byteIdx_q, byteIdx_d;
  logic [31:0]             word_q, word_d;
  logic                    tx_q, tx_d;
  logic                    bitDone;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      hp_q      <= '0;
      cnt_q     <= '0;
      half_q    <= 1'b0;
      bitIdx_q  <= '0;
      byteIdx_q <= '0;
      word_q    <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      hp_q      <= hp_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      bitIdx_q  <= bitIdx_d;
      byteIdx_q <= byteIdx_d;
      word_q    <= word_d;
      tx_q      <= tx_d;
    end
  end

  // A bit ends after two full countdowns of the half-period timer.
  assign bitDone = half_q && (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    hp_d      = hp_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    bitIdx_d  = bitIdx_q;
    byteIdx_d = byteIdx_q;
    word_d    = word_q;

    if (state_q inside {START, DATA, STOP}) begin
      if (cnt_q == '0) begin
        half_d = 1'b1;
        cnt_d  = hp_q;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d  = startAddr_i;
          rem_d   = wordCount_i;
          hp_d    = halfPeriod_i;
          state_d = (wordCount_i == '0) ? EMPTY : READ;
        end
      end
      // Empty request still reports busy for one cycle before DONE.
      EMPTY: state_d = DONE;
      READ:  state_d = LATCH;
      LATCH: begin
        word_d    = memData_i;
        byteIdx_d = '0;
        bitIdx_d  = '0;
        cnt_d     = hp_q;
        half_d    = 1'b0;
        state_d   = START;
      end
      START: begin
        if (bitDone) begin
          cnt_d    = hp_q;
          half_d   = 1'b0;
          bitIdx_d = '0;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (bitDone) begin
          word_d = {1'b0, word_q[31:1]};
          cnt_d  = hp_q;
          half_d = 1'b0;
          if (bitIdx_q == 3'd7) state_d = STOP;
          else                  bitIdx_d = bitIdx_q + 3'd1;
        end
      end
      STOP: begin
        if (bitDone) begin
          cnt_d  = hp_q;
          half_d = 1'b0;
          if (byteIdx_q != 2'd3) begin
            byteIdx_d = byteIdx_q + 2'd1;
            state_d   = START;
          end else if (rem_q != REM_ONE) begin
            addr_d  = addr_q + ADDR_ONE;
            rem_d   = rem_q - REM_ONE;
            state_d = READ;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Line level is registered from the next state so bit edges land on state entry.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = word_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx_o      = tx_q;
  assign memEn_o   = (state_q == READ);
  assign memAddr_o = addr_q;
  assign busy_o    = (state_q != IDLE) && (state_q != DONE);
  assign done_o    = (state_q == DONE);

endmodule

// File: tb/tb_reprog_dump_tx.sv
// Bench for reprog_dump_tx: a cycle-level waveform model built from bit/byte/word timing
// arithmetic plus a mid-bit sampling UART receiver, driven by table, random and corner cases.
module tb_reprog_dump_tx;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [11:0] startAddr;
  logic [12:0] wordCount;
  logic [9:0]  halfPeriod;
  logic [11:0] memAddr;
  logic        memEn;
  logic [31:0] memData;
  logic        tx, busy, done;

  reprog_dump_tx #(.ADDR_WIDTH(12), .COUNTER_MSB(9)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .startAddr_i(startAddr),
    .wordCount_i(wordCount), .halfPeriod_i(halfPeriod), .memAddr_o(memAddr),
    .memEn_o(memEn), .memData_i(memData), .tx_o(tx), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [4096];
  always @(posedge clk) if (memEn) memData <= ram[memAddr];

  int assertions = 0;
  int failures   = 0;

  typedef struct {
    logic [11:0] addr;
    logic [12:0] count;
    logic [9:0]  hp;
    int          expDoneK;
  } vec_t;
  vec_t vecs[6];

  logic        expTx[$], expEn[$], expBusy[$], expDone[$];
  logic [11:0] expAddr[$];
  logic [7:0]  expBytes[$];
  logic        gotTx[$], gotEn[$], gotBusy[$], gotDone[$];
  logic [11:0] gotAddr[$];
  logic [7:0]  rxBytes[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int modelDoneK(input int wc, input int hp);
    return (wc == 0) ? 1 : wc * (2 + 40 * 2 * (hp + 1));
  endfunction

  task automatic pushCycle(input logic t, input logic e, input logic [11:0] a,
                           input logic b, input logic d);
    expTx.push_back(t); expEn.push_back(e); expAddr.push_back(a);
    expBusy.push_back(b); expDone.push_back(d);
  endtask

  // Expected per-cycle outputs, cycle 0 being the one right after the start edge.
  task automatic buildModel(input logic [11:0] a, input int wc, input int hp);
    int          bitLen;
    logic [11:0] wa;
    logic [31:0] w;
    logic [9:0]  frame;
    expTx.delete(); expEn.delete(); expAddr.delete(); expBusy.delete();
    expDone.delete(); expBytes.delete();
    bitLen = 2 * (hp + 1);
    wa = a;
    if (wc == 0) pushCycle(1'b1, 1'b0, 12'd0, 1'b1, 1'b0);
    for (int wi = 0; wi < wc; wi++) begin
      w = ram[wa];
      pushCycle(1'b1, 1'b1, wa, 1'b1, 1'b0);
      pushCycle(1'b1, 1'b0, wa, 1'b1, 1'b0);
      for (int by = 0; by < 4; by++) begin
        expBytes.push_back(w[8*by +: 8]);
        frame = {1'b1, w[8*by +: 8], 1'b0};
        for (int i = 0; i < 10; i++)
          for (int c = 0; c < bitLen; c++) pushCycle(frame[i], 1'b0, wa, 1'b1, 1'b0);
      end
      wa = wa + 12'd1;
    end
    pushCycle(1'b1, 1'b0, wa, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) pushCycle(1'b1, 1'b0, wa, 1'b0, 1'b0);
  endtask

  // Receiver samples each bit mid-period, the way a host UART would.
  task automatic decodeRx(input int bitLen, output int frameErrs);
    int k = 1;
    int n = gotTx.size();
    logic [7:0] bv;
    rxBytes.delete();
    frameErrs = 0;
    while (k < n) begin
      if (gotTx[k] == 1'b0 && gotTx[k-1] == 1'b1) begin
        if (k + 9 * bitLen + bitLen / 2 >= n) break;
        for (int i = 0; i < 8; i++) bv[i] = gotTx[k + (i + 1) * bitLen + bitLen / 2];
        if (gotTx[k + 9 * bitLen + bitLen / 2] != 1'b1) frameErrs++;
        rxBytes.push_back(bv);
        k = k + 9 * bitLen + bitLen / 2;
      end else begin
        k++;
      end
    end
  endtask

  // mode 0: plain dump; 1: start/inputs disturbed while busy and in DONE; 2: reset in byte 2 DATA
  task automatic applyStimulus(input logic [11:0] a, input int wc, input int hp,
                               input int mode, input string tag, input int expDoneK);
    int kR = -1;
    int bitLen = 2 * (hp + 1);
    int eTx = 0, eEn = 0, eAddr = 0, eBusy = 0, eDone = 0, doneAt = -1, fe = 0, eBytes = 0;
    buildModel(a, wc, hp);
    if (mode == 2) begin
      kR = 2 + 20 * bitLen + 3 * bitLen;
      for (int k = kR + 1; k < expTx.size(); k++) begin
        expTx[k] = 1'b1; expEn[k] = 1'b0; expBusy[k] = 1'b0; expDone[k] = 1'b0;
      end
    end
    gotTx.delete(); gotEn.delete(); gotAddr.delete(); gotBusy.delete(); gotDone.delete();
    @(negedge clk);
    startAddr  = a;
    wordCount  = 13'(wc);
    halfPeriod = 10'(hp);
    start      = 1'b1;
    for (int k = 0; k < expTx.size(); k++) begin
      @(posedge clk);
      #1;
      gotTx.push_back(tx); gotEn.push_back(memEn); gotAddr.push_back(memAddr);
      gotBusy.push_back(busy); gotDone.push_back(done);
      if (k == 0) start = 1'b0;
      if (mode == 1) begin
        if (k == 5) begin
          start = 1'b1; startAddr = ~a; wordCount = 13'd5; halfPeriod = 10'(hp + 3);
        end
        if (k == 6) start = 1'b0;
        if (k == expDoneK) start = 1'b1;
        if (k == expDoneK + 1) start = 1'b0;
      end
      if (mode == 2 && k == kR) rst = 1'b1;
      if (mode == 2 && k == kR + 1) rst = 1'b0;
    end
    for (int k = 0; k < expTx.size(); k++) begin
      if (gotTx[k] !== expTx[k]) eTx++;
      if (gotEn[k] !== expEn[k]) eEn++;
      if (expEn[k] && gotAddr[k] !== expAddr[k]) eAddr++;
      if (gotBusy[k] !== expBusy[k]) eBusy++;
      if (gotDone[k] !== expDone[k]) eDone++;
      if (gotDone[k] === 1'b1 && doneAt < 0) doneAt = k;
    end
    checkOutput({tag, " tx waveform error cycles"}, eTx, 0);
    checkOutput({tag, " memEn error cycles"}, eEn, 0);
    checkOutput({tag, " memAddr error reads"}, eAddr, 0);
    checkOutput({tag, " busy error cycles"}, eBusy, 0);
    checkOutput({tag, " done error cycles"}, eDone, 0);
    checkOutput({tag, " done cycle"}, doneAt, expDoneK);
    if (mode != 2) begin
      decodeRx(bitLen, fe);
      checkOutput({tag, " rx byte count"}, rxBytes.size(), expBytes.size());
      for (int i = 0; i < rxBytes.size() && i < expBytes.size(); i++)
        if (rxBytes[i] !== expBytes[i]) eBytes++;
      checkOutput({tag, " rx byte errors"}, eBytes + fe, 0);
    end
  endtask

  initial begin
    logic [11:0] ra;
    int          rc, rh;
    rst = 1'b1; start = 1'b0; startAddr = '0; wordCount = '0; halfPeriod = '0;
    foreach (ram[i]) ram[i] = $urandom;
    ram[5] = 32'h12345678;

    vecs[0] = '{12'd5,    13'd1, 10'd1, 162};
    vecs[1] = '{12'hFFE,  13'd3, 10'd0, 246};
    vecs[2] = '{12'd7,    13'd0, 10'd2, 1};
    vecs[3] = '{12'h100,  13'd2, 10'd2, 484};
    vecs[4] = '{12'd0,    13'd1, 10'd0, 82};
    vecs[5] = '{12'hFFF,  13'd2, 10'd3, 644};

    repeat (3) @(posedge clk);
    start = 1'b1;
    @(negedge clk);
    checkOutput("reset tx", int'(tx), 1);
    checkOutput("reset memEn", int'(memEn), 0);
    checkOutput("reset memAddr", int'(memAddr), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    checkOutput("start under reset ignored busy", int'(busy), 0);

    for (int i = 0; i < 6; i++)
      applyStimulus(vecs[i].addr, int'(vecs[i].count), int'(vecs[i].hp), 0,
                    $sformatf("vec%0d", i), vecs[i].expDoneK);

    for (int i = 0; i < 4; i++) begin
      ra = 12'($urandom_range(0, 4095));
      rc = $urandom_range(0, 3);
      rh = $urandom_range(0, 4);
      applyStimulus(ra, rc, rh, 0, $sformatf("rand%0d", i), modelDoneK(rc, rh));
    end

    applyStimulus(12'h040, 2, 1, 1, "disturb", modelDoneK(2, 1));
    applyStimulus(12'd5, 1, 1, 2, "reset-abort", -1);
    applyStimulus(12'd5, 1, 1, 0, "after-reset", modelDoneK(1, 1));

    ram[12'h321] = 32'hA55A0FF0;
    applyStimulus(12'h321, 1, 433, 0, "loopback", modelDoneK(1, 433));

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
